// File: rtl/bp_me_pkg.sv
// Shared state encodings for the bypass-link memory adapter.
package bp_me_pkg;

    typedef enum logic {
        e_fill = 1'b0,
        e_full = 1'b1
    } bp_me_bypass_cmd_state_e;

    typedef enum logic {
        e_idle = 1'b0,
        e_send = 1'b1
    } bp_me_bypass_resp_state_e;

endpackage

// File: rtl/bp_me_bypass_piso.sv
// Response serializer: latches one memory message and streams it out as
// flits, lowest slot first. last_o marks the handshake of the final flit.
module bp_me_bypass_piso
    import bp_me_pkg::*;
#(
    parameter int flit_width_p = 64,
    parameter int msg_width_p  = 128
)(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [msg_width_p-1:0]  data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [flit_width_p-1:0] data_o,
    output logic                    v_o,
    input  logic                    ready_and_i,
    output logic                    last_o
);
    localparam int len_lp   = (msg_width_p + flit_width_p - 1) / flit_width_p;
    localparam int buf_w_lp = len_lp * flit_width_p;
    localparam int cnt_w_lp = $clog2(len_lp);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(len_lp - 1);

    bp_me_bypass_resp_state_e state_q;
    logic [cnt_w_lp-1:0]      cnt_q;
    logic [buf_w_lp-1:0]      buf_q;
    logic [buf_w_lp-1:0]      buf_d;

    // Zero-extend the incoming message to a whole number of flits
    always_comb begin
        buf_d = '0;
        buf_d[msg_width_p-1:0] = data_i;
    end

    // Idle/send FSM with flit counter; all outputs decode registered state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else if (state_q == e_idle) begin
            if (v_i) begin
                buf_q   <= buf_d;
                cnt_q   <= '0;
                state_q <= e_send;
            end
        end else if (ready_and_i) begin
            if (cnt_q == cnt_last_lp) begin
                cnt_q   <= '0;
                state_q <= e_idle;
            end else begin
                cnt_q <= cnt_q + cnt_w_lp'(1);
            end
        end
    end

    assign ready_o = (state_q == e_idle);
    assign v_o     = (state_q == e_send);
    assign data_o  = buf_q[cnt_q*flit_width_p +: flit_width_p];
    assign last_o  = v_o & ready_and_i & (cnt_q == cnt_last_lp);

endmodule

// File: rtl/bp_me_bypass_mem_adapter.sv
// Bypass link <-> memory model bridge: assembles command flits into messages,
// serializes responses into flits, and limits commands in flight with credits.
module bp_me_bypass_mem_adapter
    import bp_me_pkg::*;
#(
    parameter int flit_width_p      = 64,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4
)(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [flit_width_p-1:0] link_cmd_data_i,
    input  logic                    link_cmd_v_i,
    output logic                    link_cmd_ready_o,
    output logic [msg_width_p-1:0]  mem_cmd_o,
    output logic                    mem_cmd_v_o,
    input  logic                    mem_cmd_yumi_i,
    input  logic [msg_width_p-1:0]  mem_resp_i,
    input  logic                    mem_resp_v_i,
    output logic                    mem_resp_ready_o,
    output logic [flit_width_p-1:0] link_resp_data_o,
    output logic                    link_resp_v_o,
    input  logic                    link_resp_ready_and_i
);
    localparam int len_lp    = (msg_width_p + flit_width_p - 1) / flit_width_p;
    localparam int cnt_w_lp  = $clog2(len_lp);
    localparam int cred_w_lp = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_w_lp-1:0]  cnt_last_lp = cnt_w_lp'(len_lp - 1);
    localparam logic [cred_w_lp-1:0] cred_max_lp = cred_w_lp'(max_outstanding_p);

    bp_me_bypass_cmd_state_e cmd_state_q;
    logic [cnt_w_lp-1:0]     cmd_cnt_q;
    logic [msg_width_p-1:0]  cmd_buf_q;
    logic [msg_width_p-1:0]  cmd_buf_d;
    logic [cred_w_lp-1:0]    outstanding_q;
    logic [cred_w_lp-1:0]    outstanding_d;
    logic                    cmd_accept;
    logic                    cred_inc;
    logic                    cred_dec;

    // Credits gate flit acceptance even mid-message; a partial buffer just waits
    assign link_cmd_ready_o = (cmd_state_q == e_fill) && (outstanding_q < cred_max_lp);
    assign cmd_accept       = link_cmd_v_i & link_cmd_ready_o;
    assign mem_cmd_v_o      = (cmd_state_q == e_full);
    assign mem_cmd_o        = cmd_buf_q;
    assign cred_inc         = mem_cmd_yumi_i & mem_cmd_v_o;

    // Drop each flit into its slot; bits beyond the message width are never stored
    always_comb begin
        cmd_buf_d = cmd_buf_q;
        for (int j = 0; j < msg_width_p; j++) begin
            if (cmd_accept && (int'(cmd_cnt_q) == j / flit_width_p)) begin
                cmd_buf_d[j] = link_cmd_data_i[j % flit_width_p];
            end
        end
    end

    // Command assembly FSM: fill slots, then hold the message until memory takes it
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_state_q <= e_fill;
            cmd_cnt_q   <= '0;
            cmd_buf_q   <= '0;
        end else begin
            cmd_buf_q <= cmd_buf_d;
            if (cmd_state_q == e_fill) begin
                if (cmd_accept) begin
                    if (cmd_cnt_q == cnt_last_lp) begin
                        cmd_cnt_q   <= '0;
                        cmd_state_q <= e_full;
                    end else begin
                        cmd_cnt_q <= cmd_cnt_q + cnt_w_lp'(1);
                    end
                end
            end else if (mem_cmd_yumi_i) begin
                cmd_state_q <= e_fill;
            end
        end
    end

    // Credit next-state: a send and a completion in the same cycle cancel out
    always_comb begin
        outstanding_d = outstanding_q;
        if (cred_inc && !cred_dec) begin
            outstanding_d = outstanding_q + cred_w_lp'(1);
        end else if (cred_dec && !cred_inc) begin
            outstanding_d = outstanding_q - cred_w_lp'(1);
        end
    end

    // Credit register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    bp_me_bypass_piso #(
        .flit_width_p (flit_width_p),
        .msg_width_p  (msg_width_p)
    ) resp_piso (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .data_i      (mem_resp_i),
        .v_i         (mem_resp_v_i),
        .ready_o     (mem_resp_ready_o),
        .data_o      (link_resp_data_o),
        .v_o         (link_resp_v_o),
        .ready_and_i (link_resp_ready_and_i),
        .last_o      (cred_dec)
    );

`ifndef SYNTHESIS
    // Protocol checks on the memory handshake and the credit counter
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(mem_cmd_yumi_i && (cmd_state_q != e_full)))
                else $error("mem_cmd_yumi_i asserted with no assembled command");
            assert (!(cred_inc && !cred_dec && (outstanding_q == cred_max_lp)))
                else $error("credit increment beyond max_outstanding_p");
            assert (!(cred_dec && !cred_inc && (outstanding_q == '0)))
                else $error("credit decrement below zero");
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_bypass_mem_adapter.sv
`timescale 1ns/1ps
module tb_bp_me_bypass_mem_adapter;
    localparam int FW   = 8;
    localparam int MW   = 20;
    localparam int LEN  = 3;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [FW-1:0] link_cmd_data_i;
    logic          link_cmd_v_i;
    logic          link_cmd_ready_o;
    logic [MW-1:0] mem_cmd_o;
    logic          mem_cmd_v_o;
    logic          mem_cmd_yumi_i;
    logic [MW-1:0] mem_resp_i;
    logic          mem_resp_v_i;
    logic          mem_resp_ready_o;
    logic [FW-1:0] link_resp_data_o;
    logic          link_resp_v_o;
    logic          link_resp_ready_and_i;

    // bench control
    logic auto_mode, man_yumi, man_rdy, rnd_yumi, rnd_rdy;
    int   n_cmp = 0, n_fail = 0;
    int   model_out = 0, flit_idx = 0, resp_done = 0;
    logic [MW-1:0] cmd_exp[$];
    logic [FW-1:0] resp_exp[$];
    logic [MW-1:0] pending[$];

    always #5 clk = ~clk;

    assign mem_cmd_yumi_i        = auto_mode ? (rnd_yumi & mem_cmd_v_o) : man_yumi;
    assign link_resp_ready_and_i = auto_mode ? rnd_rdy : man_rdy;

    bp_me_bypass_mem_adapter #(
        .flit_width_p      (FW),
        .msg_width_p       (MW),
        .max_outstanding_p (MAXO)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .link_cmd_data_i       (link_cmd_data_i),
        .link_cmd_v_i          (link_cmd_v_i),
        .link_cmd_ready_o      (link_cmd_ready_o),
        .mem_cmd_o             (mem_cmd_o),
        .mem_cmd_v_o           (mem_cmd_v_o),
        .mem_cmd_yumi_i        (mem_cmd_yumi_i),
        .mem_resp_i            (mem_resp_i),
        .mem_resp_v_i          (mem_resp_v_i),
        .mem_resp_ready_o      (mem_resp_ready_o),
        .link_resp_data_o      (link_resp_data_o),
        .link_resp_v_o         (link_resp_v_o),
        .link_resp_ready_and_i (link_resp_ready_and_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // random handshake sources for the free-running phase
    initial begin
        rnd_yumi = 1'b0;
        rnd_rdy  = 1'b0;
        forever begin
            @(posedge clk); #1;
            rnd_yumi = ($urandom_range(0, 1) == 1);
            rnd_rdy  = ($urandom_range(0, 3) != 0);
        end
    end

    // memory response driver; pushes the expected flits when a response is taken
    initial begin
        logic acc;
        logic [MW-1:0] sh;
        mem_resp_v_i = 1'b0;
        mem_resp_i   = '0;
        forever begin
            @(negedge clk);
            acc = mem_resp_v_i && mem_resp_ready_o && !reset_i;
            if (acc) begin
                for (int i = 0; i < LEN; i++) begin
                    sh = mem_resp_i >> (FW * i);
                    resp_exp.push_back(sh[FW-1:0]);
                end
            end
            @(posedge clk); #1;
            if (reset_i) begin
                mem_resp_v_i = 1'b0;
                pending.delete();
            end else begin
                if (acc) begin
                    void'(pending.pop_front());
                    mem_resp_v_i = 1'b0;
                end
                if (!mem_resp_v_i && pending.size() > 0 &&
                    (!auto_mode || $urandom_range(0, 1) == 1)) begin
                    mem_resp_v_i = 1'b1;
                    mem_resp_i   = pending[0];
                end
            end
        end
    end

    // scoreboard monitor: commands to memory, flits to the link, credit limit
    always @(negedge clk) begin
        if (reset_i) begin
            flit_idx  = 0;
            model_out = 0;
        end else begin
            if (model_out == MAXO) chk("credit_block", link_cmd_ready_o, 0);
            if (mem_cmd_v_o && mem_cmd_yumi_i) begin
                if (cmd_exp.size() == 0) fail_now("mem_cmd", "unexpected command");
                else chk("mem_cmd", mem_cmd_o, cmd_exp.pop_front());
                model_out++;
                if (auto_mode) pending.push_back(MW'($urandom));
            end
            if (link_resp_v_o && link_resp_ready_and_i) begin
                if (resp_exp.size() == 0) fail_now("resp_flit", "unexpected flit");
                else chk("resp_flit", link_resp_data_o, resp_exp.pop_front());
                flit_idx++;
                if (flit_idx == LEN) begin
                    flit_idx = 0;
                    model_out--;
                    resp_done++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_flit(input logic [FW-1:0] d);
        int   t;
        logic acc;
        t = 0;
        link_cmd_v_i    = 1'b1;
        link_cmd_data_i = d;
        do begin
            @(negedge clk);
            acc = link_cmd_ready_o;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 300);
        if (!acc) fail_now("cmd_flit", "flit never accepted");
        link_cmd_v_i = 1'b0;
    endtask

    // reference: message = flits concatenated low slot first, truncated to MW bits
    task automatic send_cmd(input logic [FW-1:0] f0, input logic [FW-1:0] f1, input logic [FW-1:0] f2);
        int unsigned m;
        m = (int'(f0) + int'(f1) * 256 + int'(f2) * 65536) % (1 << MW);
        cmd_exp.push_back(MW'(m));
        drive_flit(f0);
        drive_flit(f1);
        drive_flit(f2);
    endtask

    task automatic yumi_once();
        man_yumi = 1'b1;
        tick();
        man_yumi = 1'b0;
    endtask

    task automatic wait_resp_v();
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!link_resp_v_o && t < 50);
        if (!link_resp_v_o) fail_now("resp_start", "response never started");
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        do begin @(negedge clk); #1; t++; end while (resp_done < target && t < 200);
        if (resp_done < target) fail_now("resp_done", "response never completed");
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin @(negedge clk); #1; t++; end
        while (!(model_out == 0 && cmd_exp.size() == 0 && resp_exp.size() == 0 &&
                 pending.size() == 0 && !link_resp_v_o) && t < 3000);
        if (t >= 3000) fail_now("drain", "traffic did not drain");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MW-1:0] rv, sh;
        logic [4:0]    pat;
        int            idx, t, base;
        reset_i = 1'b1; auto_mode = 1'b0; man_yumi = 1'b0; man_rdy = 1'b0;
        link_cmd_v_i = 1'b0; link_cmd_data_i = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", link_cmd_ready_o, 1);
        chk("rst_cmd_v", mem_cmd_v_o, 0);
        chk("rst_resp_ready", mem_resp_ready_o, 1);
        chk("rst_resp_v", link_resp_v_o, 0);
        chk("rst_cmd_data", mem_cmd_o, 0);
        chk("rst_resp_data", link_resp_data_o, 0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        tick();

        // single command
        send_cmd(8'h11, 8'h22, 8'h03);
        chk("cmd_v_next_cycle", mem_cmd_v_o, 1);
        chk("cmd_data", mem_cmd_o, 20'h32211);
        chk("cmd_ready_while_full", link_cmd_ready_o, 0);
        yumi_once();
        chk("cmd_ready_after_yumi", link_cmd_ready_o, 1);
        chk("cmd_v_after_yumi", mem_cmd_v_o, 0);

        // single response, ready held high
        man_rdy = 1'b1;
        rv = 20'hABCDE;
        pending.push_back(rv);
        t = 0;
        do begin @(negedge clk); t++; end while (!(mem_resp_v_i && mem_resp_ready_o) && t < 50);
        for (int i = 0; i < LEN; i++) begin
            @(negedge clk);
            sh = rv >> (FW * i);
            chk("single_resp_v", link_resp_v_o, 1);
            chk("single_resp_data", link_resp_data_o, sh[FW-1:0]);
            chk("single_resp_ready_busy", mem_resp_ready_o, 0);
        end
        @(negedge clk);
        chk("single_resp_v_end", link_resp_v_o, 0);
        chk("single_resp_ready_back", mem_resp_ready_o, 1);
        @(posedge clk); #1;
        man_rdy = 1'b0;

        // credit stall: two commands with no responses
        send_cmd(8'($urandom), 8'($urandom), 8'($urandom));
        yumi_once();
        send_cmd(8'($urandom), 8'($urandom), 8'($urandom));
        yumi_once();
        chk("stall_ready", link_cmd_ready_o, 0);
        link_cmd_v_i = 1'b1;
        link_cmd_data_i = 8'h77;
        repeat (3) begin
            @(negedge clk);
            chk("stall_flit_refused", link_cmd_ready_o, 0);
        end
        @(posedge clk); #1;
        link_cmd_v_i = 1'b0;
        base = resp_done;
        pending.push_back(MW'($urandom));
        man_rdy = 1'b1;
        wait_done(base + 1);
        @(negedge clk);
        chk("stall_ready_returns", link_cmd_ready_o, 1);
        pending.push_back(MW'($urandom));
        wait_done(base + 2);
        @(posedge clk); #1;
        man_rdy = 1'b0;

        // response backpressure 1,0,0,1,1
        send_cmd(8'($urandom), 8'($urandom), 8'($urandom));
        yumi_once();
        rv = 20'h5A3C9;
        pending.push_back(rv);
        wait_resp_v();
        @(posedge clk); #1;
        pat = 5'b11001;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            man_rdy = pat[k];
            @(negedge clk);
            sh = rv >> (FW * idx);
            chk("bp_resp_v", link_resp_v_o, 1);
            chk("bp_resp_data", link_resp_data_o, sh[FW-1:0]);
            chk("bp_resp_ready_low", mem_resp_ready_o, 0);
            if (pat[k]) idx++;
            @(posedge clk); #1;
        end
        man_rdy = 1'b0;
        @(negedge clk);
        chk("bp_resp_ready_back", mem_resp_ready_o, 1);
        chk("bp_resp_v_end", link_resp_v_o, 0);
        @(posedge clk); #1;

        // yumi and last response flit in the same cycle
        send_cmd(8'($urandom), 8'($urandom), 8'($urandom));
        yumi_once();
        pending.push_back(MW'($urandom));
        wait_resp_v();
        @(posedge clk); #1;
        send_cmd(8'($urandom), 8'($urandom), 8'($urandom));
        man_rdy = 1'b1;
        tick();
        tick();
        man_yumi = 1'b1;
        tick();
        man_yumi = 1'b0;
        man_rdy = 1'b0;
        send_cmd(8'($urandom), 8'($urandom), 8'($urandom));
        chk("simul_ready_full", link_cmd_ready_o, 0);
        yumi_once();
        chk("simul_credits_at_max", link_cmd_ready_o, 0);
        pending.push_back(MW'($urandom));
        pending.push_back(MW'($urandom));
        man_rdy = 1'b1;
        wait_idle();
        chk("simul_drained_ready", link_cmd_ready_o, 1);
        @(posedge clk); #1;
        man_rdy = 1'b0;

        // reset with a partial command and a response in flight
        send_cmd(8'($urandom), 8'($urandom), 8'($urandom));
        yumi_once();
        pending.push_back(MW'($urandom));
        wait_resp_v();
        @(posedge clk); #1;
        drive_flit(8'h99);
        #2;
        reset_i = 1'b1;
        cmd_exp.delete();
        resp_exp.delete();
        pending.delete();
        #1;
        chk("mrst_cmd_v", mem_cmd_v_o, 0);
        chk("mrst_resp_v", link_resp_v_o, 0);
        chk("mrst_cmd_ready", link_cmd_ready_o, 1);
        chk("mrst_resp_ready", mem_resp_ready_o, 1);
        @(posedge clk); #1;
        reset_i = 1'b0;
        man_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_no_flit", link_resp_v_o, 0);
        end
        @(posedge clk); #1;
        send_cmd(8'h44, 8'h55, 8'hAF);
        chk("mrst_fresh_v", mem_cmd_v_o, 1);
        chk("mrst_fresh_data", mem_cmd_o, 20'hF5544);
        yumi_once();
        pending.push_back(MW'($urandom));
        wait_idle();
        @(posedge clk); #1;

        // randomized traffic with random yumi and link backpressure
        auto_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_cmd(8'($urandom), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_me_bypass_mem_adapter.md
# bp_me_bypass_mem_adapter

Bridges the bypass link to the memory model: it reassembles narrow bypass command flits into full memory command messages and splits memory responses back into bypass flits. It sits directly downstream of the bypass command link and directly upstream of `bp_mem`, and it replaces the ad-hoc SIPO/PISO pair in the top-level benches. A credit counter bounds the number of commands issued to memory without a returned response.

## Interface
Parameters:
- `flit_width_p`, default 64: bypass flit width.
- `msg_width_p`, default 128: memory message width, command and response.
- `max_outstanding_p`, default 4: maximum number of commands in flight at memory.
- `len_lp` (derived): `ceil(msg_width_p / flit_width_p)`, flits per message, required ≥ 2.

Ports (all widths in bits):
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `link_cmd_data_i`, in, `flit_width_p`: incoming command flit.
- `link_cmd_v_i`, in, 1: incoming command flit valid.
- `link_cmd_ready_o`, out, 1: adapter can accept a command flit.
- `mem_cmd_o`, out, `msg_width_p`: assembled command message.
- `mem_cmd_v_o`, out, 1: assembled command valid.
- `mem_cmd_yumi_i`, in, 1: memory consumes the command.
- `mem_resp_i`, in, `msg_width_p`: memory response message.
- `mem_resp_v_i`, in, 1: memory response valid.
- `mem_resp_ready_o`, out, 1: adapter can accept a response (ready/valid).
- `link_resp_data_o`, out, `flit_width_p`: outgoing response flit.
- `link_resp_v_o`, out, 1: outgoing response flit valid.
- `link_resp_ready_and_i`, in, 1: link accepts the response flit.

## Operation
- **Command path**
  - FSM states: `e_fill`, `e_full`; reset state is `e_fill` with `cmd_cnt` = 0.
  - In `e_fill`: `link_cmd_ready_o` = (`outstanding` < `max_outstanding_p`). An accepted flit (v & ready) is written to slot `cmd_cnt`, bits `[cmd_cnt*flit_width_p +: flit_width_p]`, and `cmd_cnt` increments.
  - On the flit with `cmd_cnt == len_lp-1`: go to `e_full` and reset `cmd_cnt` to 0.
  - In `e_full`: `mem_cmd_v_o` = 1 and `link_cmd_ready_o` = 0. `mem_cmd_o` is the low `msg_width_p` bits of the buffer; pad bits of the last flit are discarded.
  - On `mem_cmd_yumi_i`: go to `e_fill` and increment `outstanding`.
  - `mem_cmd_yumi_i` while not in `e_full` is illegal and must be caught by an assertion.
- **Response path**
  - FSM states: `e_idle`, `e_send`.
  - In `e_idle`: `mem_resp_ready_o` = 1. An accepted response is latched zero-extended to `len_lp*flit_width_p` bits, and the FSM goes to `e_send` with `resp_cnt` = 0.
  - In `e_send`: `link_resp_v_o` = 1 and `link_resp_data_o` = slot `resp_cnt`. On `link_resp_ready_and_i`, `resp_cnt` increments.
  - After the last flit is accepted: go to `e_idle` and decrement `outstanding`.
- **Credits**
  - `outstanding` counter width is `clog2(max_outstanding_p+1)`.
  - Increment and decrement in the same cycle leave it unchanged.
  - Decrement at 0 and increment at max are illegal (assertions).
  - When `outstanding == max_outstanding_p`, `link_cmd_ready_o` = 0 even mid-message. A partially filled buffer holds its contents.
- **Reset mid-operation**: a partial command, a latched response and all counters are discarded. No flit is emitted after reset.

## Timing
- Reset values:
  - `link_cmd_ready_o` = 1 (credits are full).
  - `mem_cmd_v_o` = 0.
  - `mem_resp_ready_o` = 1.
  - `link_resp_v_o` = 0.
  - `mem_cmd_o` and `link_resp_data_o` = 0.
- Command latency: `mem_cmd_v_o` rises the cycle after the last flit is accepted. `link_cmd_ready_o` returns the cycle after yumi, a one-cycle bubble per message.
- Response latency: `link_resp_v_o` rises the cycle after the response is accepted. Flits stream back-to-back while ready is high. `mem_resp_ready_o` rises the cycle after the last flit is accepted.
- All outputs are registered or decode state only. There is no combinational path from any input to any valid or ready output, except that `link_cmd_ready_o` depends on registered `outstanding`.
- Command and response paths operate concurrently and independently apart from the credits.

## Structure
- State enums (`bp_me_bypass_cmd_state_e`, `bp_me_bypass_resp_state_e`) belong in `bp_me_pkg`.
- `len_lp` is a module localparam.
- The response serializer is a natural sub-module, `bp_me_bypass_piso`, with a valid/ready input and valid/ready_and output. The command path and credits stay in the top module.

## Test plan
All scenarios use `flit_width_p`=8, `msg_width_p`=20, `len_lp`=3, `max_outstanding_p`=2.
- **Single command**: flits 0x11, 0x22, 0x03 on consecutive cycles → `mem_cmd_o` = 0x32211, and `mem_cmd_v_o` is high the cycle after the third flit.
- **Single response**: 0xABCDE returned → flits 0xDE, 0xBC, 0x0A on three consecutive cycles with ready held high. `outstanding` goes from 1 to 0.
- **Credit stall**: two commands issued with no responses → `link_cmd_ready_o` is 0 and a third flit is not accepted. One response completes → ready returns the next cycle.
- **Response backpressure**: `link_resp_ready_and_i` toggling 1,0,0,1,1 → the data slot is held while stalled, and `mem_resp_ready_o` stays 0 until the third flit is accepted.
- **Simultaneous events**: a command yumi and the last response flit in the same cycle → `outstanding` is unchanged and no assertion fires.
- **Mid-message reset**: `reset_i` is asserted after 1 of 3 command flits and mid-response → all valids are 0 immediately (asynchronous). After release, a fresh 3-flit command assembles correctly.
